// File: rtl/dp_alarm_pkg.sv
// Shared types and default timing constants for the detect-alarm path.
package dp_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEEP    = 2'd1,
    HOLDOFF = 2'd2
  } alarm_state_t;

  // Defaults for a 50 MHz clock
  localparam int DEF_TONE_HALF      = 6250;      // 4 kHz tone
  localparam int DEF_BEEP_CYCLES    = 50000000;  // 1 s of tone
  localparam int DEF_HOLDOFF_CYCLES = 25000000;  // 0.5 s refractory
  localparam int DEF_LED_STRETCH    = 5000000;   // 100 ms LED pulse

  // Counter width for a 0..n-1 counter, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a single-cycle trigger into a registered pulse of at least LEN
// cycles; a retrigger while lit restarts the count.
module pulse_stretch
  import dp_alarm_pkg::*;
#(
  parameter int LEN = DEF_LED_STRETCH
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic out
);

  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] RELOAD = CW'(LEN - 1);

  logic [CW-1:0] cnt;

  // Reload on trigger, otherwise count down; the output stays high through
  // the cycle in which the counter reaches zero, giving LEN cycles in total
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (trig) begin
      cnt <= RELOAD;
      out <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      out <= (cnt != '0);
    end
  end

endmodule

// File: rtl/detect_alarm.sv
// Confirms a word detection after HITS consecutive positive frames, gates a
// square-wave tone onto the piezo, then holds off further alarms for a while.
// Also stretches frame-positive and VAD indications for the board LEDs.
module detect_alarm
  import dp_alarm_pkg::*;
#(
  parameter int HITS           = 2,
  parameter int TONE_HALF      = DEF_TONE_HALF,
  parameter int BEEP_CYCLES    = DEF_BEEP_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int LED_STRETCH    = DEF_LED_STRETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       result_dv,
  input  logic       result,
  input  logic       vad_i,
  output logic       beep,
  output logic       led_detect,
  output logic       led_vad,
  output logic       alarm_busy,
  output logic [7:0] alarm_count
);

  localparam int TW = cnt_w(TONE_HALF);
  localparam int DW = cnt_w(BEEP_CYCLES);
  localparam int HW = cnt_w(HOLDOFF_CYCLES);

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [DW-1:0] DUR_LAST  = DW'(BEEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [3:0]    HITS_V    = 4'(HITS);

  alarm_state_t  state;
  logic [3:0]    hit_cnt;
  logic [3:0]    hit_nxt;
  logic [TW-1:0] tone_cnt;
  logic [DW-1:0] dur_cnt;
  logic [HW-1:0] hold_cnt;

  assign hit_nxt = hit_cnt + 4'd1;

  // Alarm FSM with inline tone, duration and hold-off counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hit_cnt     <= '0;
      tone_cnt    <= '0;
      dur_cnt     <= '0;
      hold_cnt    <= '0;
      beep        <= 1'b0;
      alarm_busy  <= 1'b0;
      alarm_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (result_dv) begin
            if (result) begin
              if (hit_nxt == HITS_V) begin
                state       <= BEEP;
                hit_cnt     <= '0;
                tone_cnt    <= '0;
                dur_cnt     <= '0;
                beep        <= 1'b1;
                alarm_busy  <= 1'b1;
                alarm_count <= alarm_count + 8'd1;
              end else begin
                hit_cnt <= hit_nxt;
              end
            end else begin
              hit_cnt <= '0;
            end
          end
        end

        BEEP: begin
          hit_cnt <= '0;
          if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            beep     <= ~beep;
          end else begin
            tone_cnt <= tone_cnt + TW'(1);
          end
          // End of the tone window overrides the toggle above
          if (dur_cnt == DUR_LAST) begin
            state    <= HOLDOFF;
            dur_cnt  <= '0;
            hold_cnt <= '0;
            beep     <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt + DW'(1);
          end
        end

        HOLDOFF: begin
          beep    <= 1'b0;
          hit_cnt <= '0;
          if (hold_cnt == HOLD_LAST) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            alarm_busy <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: begin
          state      <= IDLE;
          beep       <= 1'b0;
          alarm_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered VAD copy for the LED pin
  always_ff @(posedge clk) begin
    if (reset) led_vad <= 1'b0;
    else       led_vad <= vad_i;
  end

  pulse_stretch #(
    .LEN (LED_STRETCH)
  ) u_led_stretch (
    .clk   (clk),
    .reset (reset),
    .trig  (result_dv & result),
    .out   (led_detect)
  );

endmodule

// File: tb/tb_detect_alarm.sv
// Directed bench for detect_alarm with shortened timing parameters.
module tb_detect_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic       result_dv;
  logic       result;
  logic       vad_i;
  logic       beep;
  logic       led_detect;
  logic       led_vad;
  logic       alarm_busy;
  logic [7:0] alarm_count;

  int n_tests = 0;
  int n_fail  = 0;

  detect_alarm #(
    .HITS           (2),
    .TONE_HALF      (4),
    .BEEP_CYCLES    (32),
    .HOLDOFF_CYCLES (16),
    .LED_STRETCH    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .result_dv   (result_dv),
    .result      (result),
    .vad_i       (vad_i),
    .beep        (beep),
    .led_detect  (led_detect),
    .led_vad     (led_vad),
    .alarm_busy  (alarm_busy),
    .alarm_count (alarm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs then reflect that edge's update
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic strobe(input logic r);
    result_dv = 1'b1;
    result    = r;
    tick();
    result_dv = 1'b0;
    result    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    result_dv = 1'b0;
    result    = 1'b0;
    vad_i     = 1'b0;
    ticks(3);

    // Reset state
    check("rst_beep", beep, 0);
    check("rst_led_detect", led_detect, 0);
    check("rst_led_vad", led_vad, 0);
    check("rst_busy", alarm_busy, 0);
    check("rst_count", alarm_count, 0);
    reset = 1'b0;
    tick();

    // Two positive frames 10 cycles apart fire one alarm
    strobe(1'b1);
    check("t1_first_no_busy", alarm_busy, 0);
    check("t1_first_led", led_detect, 1);
    ticks(9);
    strobe(1'b1);
    check("t1_count", alarm_count, 1);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("t1_busy_%0d", i), alarm_busy, 1);
      if (i < 32) check($sformatf("t1_beep_%0d", i), beep, ((i / 4) % 2 == 0) ? 1 : 0);
      else        check($sformatf("t1_beep_hold_%0d", i), beep, 0);
      tick();
    end
    check("t1_busy_end", alarm_busy, 0);
    check("t1_beep_end", beep, 0);

    // 1,0,1 must not fire
    do_reset();
    strobe(1'b1);
    ticks(3);
    strobe(1'b0);
    ticks(3);
    strobe(1'b1);
    check("t2_busy", alarm_busy, 0);
    check("t2_beep", beep, 0);
    check("t2_count", alarm_count, 0);

    // Positive frames during HOLDOFF are ignored
    do_reset();
    strobe(1'b1);
    strobe(1'b1);
    check("t3_fire1", alarm_count, 1);
    ticks(33);
    check("t3_in_hold_beep", beep, 0);
    strobe(1'b1);
    strobe(1'b1);
    check("t3_hold_count", alarm_count, 1);
    check("t3_hold_busy", alarm_busy, 1);
    ticks(13);
    check("t3_idle_busy", alarm_busy, 0);
    strobe(1'b1);
    check("t3_one_hit_busy", alarm_busy, 0);
    strobe(1'b1);
    check("t3_fire2", alarm_count, 2);
    check("t3_fire2_beep", beep, 1);

    // Reset mid-BEEP abandons the alarm
    do_reset();
    strobe(1'b1);
    strobe(1'b1);
    ticks(10);
    check("t4_pre_busy", alarm_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_beep", beep, 0);
    check("t4_busy", alarm_busy, 0);
    check("t4_count", alarm_count, 0);
    strobe(1'b1);
    strobe(1'b1);
    check("t4_refire_count", alarm_count, 1);
    check("t4_refire_beep", beep, 1);

    // LED stretch: single strobe gives 8 cycles
    do_reset();
    strobe(1'b1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t5_led_%0d", i), led_detect, (i < 8) ? 1 : 0);
      tick();
    end
    // Retrigger 5 cycles after the first extends through cycle 12
    do_reset();
    strobe(1'b1);
    for (int i = 0; i < 14; i++) begin
      check($sformatf("t5_ext_%0d", i), led_detect, (i <= 12) ? 1 : 0);
      if (i == 4) strobe(1'b1);
      else        tick();
    end

    // VAD is a one-register delay
    vad_i = 1'b1;
    #1;
    check("t6_vad_before_edge", led_vad, 0);
    tick();
    check("t6_vad_hi", led_vad, 1);
    vad_i = 1'b0;
    tick();
    check("t6_vad_lo", led_vad, 0);

    // alarm_count wraps after 256 alarms
    do_reset();
    for (int a = 1; a <= 256; a++) begin
      strobe(1'b1);
      strobe(1'b1);
      if (a == 255) check("t7_count_255", alarm_count, 255);
      if (a == 256) check("t7_count_wrap", alarm_count, 0);
      ticks(48);
    end
    check("t7_idle_after", alarm_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detect_alarm.md
# detect_alarm

Downstream consumer of the word-detect stage's per-frame decision stream (`result_dv`/`result`/`vad`). Confirms a detection only after a run of consecutive positive frames, then drives the piezo with a gated square-wave tone for a fixed duration and applies a refractory hold-off. It also stretches the detect and VAD indications into human-visible LED pulses. It replaces the ad-hoc LED/beep logic in the top level and sits between the word-detect block and the board pins.

## Interface
Parameters:
- `HITS`, 2: number of consecutive `result=1` frames required to fire (1..15).
- `TONE_HALF`, 6250: clk cycles per tone half-period (4 kHz at 50 MHz).
- `BEEP_CYCLES`, 50000000: clk cycles the tone is gated on.
- `HOLDOFF_CYCLES`, 25000000: clk cycles of refractory period after the beep.
- `LED_STRETCH`, 5000000: minimum on-time of `led_detect`, in clk cycles.

Ports:
- `clk`  in  1  global clock (50 MHz); one clock domain.
- `reset`  in  1  synchronous, active-high.
- `result_dv`  in  1  single-cycle strobe, one per analysed frame.
- `result`  in  1  frame decision, valid when `result_dv`=1.
- `vad_i`  in  1  voice-activity level from the word-detect block.
- `beep`  out  1  piezo drive.
- `led_detect`  out  1  stretched frame-positive indicator.
- `led_vad`  out  1  registered copy of `vad_i`.
- `alarm_busy`  out  1  high in BEEP or HOLDOFF.
- `alarm_count`  out  8  number of alarms fired; wraps from 255 to 0.

## Operation
- FSM states: IDLE, BEEP, HOLDOFF. Reset enters IDLE.
- IDLE transitions, on `result_dv`:
  - `result`=1: hit counter increments. If the new value equals `HITS`, go to BEEP, clear the hit counter, and increment `alarm_count`.
  - `result`=0: hit counter clears to 0.
  - Without `result_dv`, the hit counter holds.
- BEEP:
  - Tone counter runs 0..`TONE_HALF`-1. `beep` toggles at each wrap, starting at 1.
  - Duration counter runs 0..`BEEP_CYCLES`-1. At terminal count, go to HOLDOFF.
  - `result_dv` is ignored; the hit counter stays 0.
- HOLDOFF:
  - `beep`=0. Counter runs 0..`HOLDOFF_CYCLES`-1, then go to IDLE with the hit counter at 0.
  - Frames are ignored. Positive frames arriving during HOLDOFF do not count toward the next alarm.
- `led_detect`:
  - Any `result_dv`&`result` (in any state) reloads the stretch counter to `LED_STRETCH`-1.
  - The LED is high while the counter is nonzero or during the reload cycle.
  - A retrigger while lit extends the pulse.
- `led_vad`: `vad_i` delayed by one register.
- Width rules:
  - Counters are sized by `$clog2` of their parameter.
  - Hit counter is 4 bits.
  - `alarm_count` is 8-bit modulo.

## Timing
- Reset values: `beep`=0, `led_detect`=0, `led_vad`=0, `alarm_busy`=0, `alarm_count`=0. All internal counters are 0 and the state is IDLE.
- Reset is sampled every cycle. A reset asserted mid-BEEP forces `beep`=0 on the next edge; the alarm is abandoned.
- Fire latency: on the clk edge that samples the qualifying `result_dv`, the state becomes BEEP. In that same registered update, `beep`=1, `alarm_busy`=1 and `alarm_count`+1 become visible.
- `beep` high exactly `TONE_HALF` cycles, low `TONE_HALF` cycles, repeating. It is forced 0 on the first HOLDOFF cycle. Total BEEP dwell is exactly `BEEP_CYCLES`.
- `alarm_busy` falls on the first IDLE cycle after HOLDOFF. A `result_dv` in that same cycle is processed normally.
- `HITS`=1: a single positive frame fires.
- `result_dv` on consecutive cycles is legal, and each strobe is counted.

## Structure
- Shared package `dp_alarm_pkg`: FSM state enum (IDLE/BEEP/HOLDOFF, 2 bits) and default parameter constants (tone, beep, holdoff, stretch at 50 MHz).
- One sub-module, `pulse_stretch`, with parameter LEN, ports clk/reset/trig/out. It is used for `led_detect`.
- The tone and duration counters stay inline in the FSM.

## Test plan
All cases use `TONE_HALF`=4, `BEEP_CYCLES`=32, `HOLDOFF_CYCLES`=16, `LED_STRETCH`=8, `HITS`=2.
- Frames 1,1 (`result_dv` 10 cycles apart) -> BEEP starts the cycle after the 2nd strobe. `beep` pattern 1111 0000 ×4, `alarm_count`=1, `alarm_busy` high for 48 cycles.
- Frames 1,0,1 -> no alarm; `alarm_count`=0, `beep` stays 0.
- Frames 1,1 then 1,1 during HOLDOFF -> no second alarm. The next 1,1 after IDLE returns yields `alarm_count`=2.
- `reset` pulsed 10 cycles into BEEP -> `beep`=0, `alarm_busy`=0, `alarm_count`=0 next cycle. A subsequent 1,1 fires normally.
- Single positive strobe -> `led_detect` high 8 cycles. A second strobe at cycle 5 extends it to cycle 13.
- 256 alarms -> `alarm_count` wraps to 0.
